// File: rtl/uc_fp.sv
// Control sequencer for the fd floating-point add/multiply datapath.
// Optional macro UC_FP_ROUND_RETRY_EN enables the post-round renormalization retry.
module uc_fp #(
    parameter int MULT_CYCLES = 28,
    parameter int NORM_POS    = 25,
    parameter int MAX_ALIGN   = 27
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [7:0]  exp_dif,
    input  logic [26:0] ula,
    input  logic [25:0] round_fract,
    output logic        sinalMuxFP1,
    output logic        sinalMuxFP2,
    output logic        sinalMuxFP3,
    output logic        sinalMuxFP4,
    output logic        sinalMuxFP5,
    output logic [7:0]  sinalShiftFract,
    output logic [8:0]  sinalShiftRes,
    output logic [8:0]  sinalIncOrDec,
    output logic        sinalRound,
    output logic        mult_rst,
    output logic        busy,
    output logic        done,
    output logic        op_err,
    output logic        zero
);
    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [4:0] NORM_P = 5'(NORM_POS);
    localparam logic [7:0] ALIGN_SAT = 8'(MAX_ALIGN);

    typedef enum logic [2:0] {IDLE, EXP, ALIGN, MULT_WAIT, NORM, ROUND, CHECK, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sel;
    logic [4:0]       lead;
    logic             nz;
    logic [7:0]       align_amt;

    // Highest set bit of the ALU magnitude; lead is meaningless when nz is low.
    always_comb begin
        lead = '0;
        for (int i = 0; i < 27; i++)
            if (ula[i]) lead = 5'(i);
    end
    assign nz        = |ula;
    assign align_amt = (exp_dif > ALIGN_SAT) ? ALIGN_SAT : exp_dif;

`ifdef UC_FP_ROUND_RETRY_EN
    logic fp45;
    logic retry;
    assign sinalMuxFP4 = fp45;
    assign sinalMuxFP5 = fp45;
`else
    logic unused_round_fract;
    assign unused_round_fract = ^round_fract;
    assign sinalMuxFP4 = 1'b0;
    assign sinalMuxFP5 = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            sel             <= 1'b0;
            sinalMuxFP1     <= 1'b0;
            sinalMuxFP2     <= 1'b0;
            sinalMuxFP3     <= 1'b0;
            sinalShiftFract <= '0;
            sinalShiftRes   <= '0;
            sinalIncOrDec   <= '0;
            sinalRound      <= 1'b0;
            mult_rst        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            op_err          <= 1'b0;
            zero            <= 1'b0;
`ifdef UC_FP_ROUND_RETRY_EN
            fp45            <= 1'b0;
            retry           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
`ifdef UC_FP_ROUND_RETRY_EN
                    retry <= 1'b0;
`endif
                    if (op == 2'b00) begin
                        sel   <= (exp_b > exp_a);
                        state <= EXP;
                    end else if (op == 2'b01) begin
                        mult_rst <= 1'b1;
                        cnt      <= '0;
                        state    <= MULT_WAIT;
                    end else begin
                        op_err <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                EXP: begin
                    sinalMuxFP1 <= sel;
                    sinalMuxFP2 <= sel;
                    sinalMuxFP3 <= ~sel;
                    state       <= ALIGN;
                end
                ALIGN: begin
                    sinalShiftFract <= align_amt;
                    state           <= NORM;
                end
                MULT_WAIT: begin
                    mult_rst <= 1'b0;
                    if (cnt == CNT_LAST) state <= NORM;
                    else                 cnt   <= cnt + 1'b1;
                end
                NORM: begin
`ifdef UC_FP_ROUND_RETRY_EN
                    fp45 <= 1'b0;
`endif
                    if (!nz) begin
                        zero  <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        if (lead > NORM_P) begin
                            sinalShiftRes <= {4'b0000, lead - NORM_P};
                            sinalIncOrDec <= {4'b0000, lead - NORM_P};
                        end else begin
                            // lead == NORM_P yields a zero amount with the direction bit moot
                            sinalShiftRes <= {(lead != NORM_P), 3'b000, NORM_P - lead};
                            sinalIncOrDec <= {(lead != NORM_P), 3'b000, NORM_P - lead};
                        end
                        sinalRound <= 1'b1;
                        state      <= ROUND;
                    end
                end
                ROUND: begin
                    sinalRound <= 1'b0;
`ifdef UC_FP_ROUND_RETRY_EN
                    state <= CHECK;
`else
                    done  <= 1'b1;
                    state <= DONE;
`endif
                end
`ifdef UC_FP_ROUND_RETRY_EN
                CHECK: begin
                    // Rounding carried out of the fraction: shift right once and re-round.
                    if (round_fract[25] && !retry) begin
                        retry         <= 1'b1;
                        fp45          <= 1'b1;
                        sinalShiftRes <= 9'h001;
                        sinalIncOrDec <= 9'h001;
                        sinalRound    <= 1'b1;
                        state         <= ROUND;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    done            <= 1'b0;
                    op_err          <= 1'b0;
                    zero            <= 1'b0;
                    busy            <= 1'b0;
                    sinalMuxFP1     <= 1'b0;
                    sinalMuxFP2     <= 1'b0;
                    sinalMuxFP3     <= 1'b0;
                    sinalShiftFract <= '0;
                    sinalShiftRes   <= '0;
                    sinalIncOrDec   <= '0;
`ifdef UC_FP_ROUND_RETRY_EN
                    fp45            <= 1'b0;
`endif
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uc_fp.md
Name: uc_fp

Overview:
- Control unit for the floating-point add/multiply datapath (`fd`).
- Sequences one operation per `start`:
  - exponent compare and alignment (add), or iterative-multiplier run (mult);
  - normalization of the ALU result;
  - rounding, then optional post-round renormalization.
- Drives every `sinal*` select/shift input of `fd` and the multiplier's `reset`.
- Consumes the `exp_dif`, `ula` and `round_fract` observation outputs of `fd`.

Parameters:
- MULT_CYCLES, 28: cycles `MULT_WAIT` holds after releasing the multiplier reset before `ula` is read.
- NORM_POS, 25: target bit index of the leading one in `ula[26:0]` after normalization.
- MAX_ALIGN, 27: saturation value for `sinalShiftFract`.

Ports:
- clock  in  1  datapath clock, rising edge
- reset  in  1  asynchronous active-high reset
- start  in  1  begin operation; sampled in IDLE only
- op  in  2  00 add, 01 mult, 10/11 illegal
- exp_a  in  8  operand A biased exponent
- exp_b  in  8  operand B biased exponent
- exp_dif  in  8  registered absolute exponent difference from datapath
- ula  in  27  ALU magnitude result
- round_fract  in  26  rounding register fraction; bit 25 = rounding carry-out
- sinalMuxFP1, sinalMuxFP2, sinalMuxFP3  out  1 each  operand-order selects
- sinalMuxFP4, sinalMuxFP5  out  1 each  0 = fresh ALU path, 1 = round feedback path
- sinalShiftFract  out  8  alignment right-shift amount
- sinalShiftRes  out  9  bit 8 = 1 left / 0 right; [7:0] amount
- sinalIncOrDec  out  9  bit 8 = 1 subtract / 0 add; [7:0] amount
- sinalRound  out  1  enable rounding in round register
- mult_rst  out  1  reset pulse to multiplier registers
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- op_err  out  1  valid with done; illegal op
- zero  out  1  valid with done; ALU magnitude was zero

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0. Reset mid-operation aborts to IDLE within the same cycle; no done.
- All outputs are registered and held stable between state changes.
- IDLE:
  - start=1 with op=00: latch sel = (exp_b > exp_a); equal exponents give sel=0; go EXP.
  - start=1 with op=01: mult_rst=1 for one cycle; go MULT_WAIT.
  - start=1 with op=1x: go DONE with op_err=1.
  - start while busy is ignored.
- Select outputs, set in EXP: sinalMuxFP1=sel, sinalMuxFP2=sel, sinalMuxFP3=~sel. They hold until IDLE.
- EXP: one wait cycle for the exponent register; go ALIGN.
- ALIGN: sinalShiftFract = min(exp_dif, MAX_ALIGN); go NORM next cycle.
- MULT_WAIT:
  - mult_rst drops on entry; counter counts 0..MULT_CYCLES-1.
  - At terminal count go NORM. sinalShiftFract stays 0.
- NORM: sinalMuxFP4=0, sinalMuxFP5=0; m = index of highest 1 in ula[26:0].
  - ula==0: zero=1; go DONE.
  - m>NORM_POS: sinalShiftRes={0, m-NORM_POS}; sinalIncOrDec={0, m-NORM_POS}.
  - m<NORM_POS: sinalShiftRes={1, NORM_POS-m}; sinalIncOrDec={1, NORM_POS-m}.
  - m==NORM_POS: both 0.
  - Go ROUND.
- ROUND: sinalRound=1 for exactly one cycle, so the round register captures the rounded value; go CHECK.
- CHECK:
  - round_fract[25]=1: sinalMuxFP4=1, sinalMuxFP5=1, sinalShiftRes={0,1}, sinalIncOrDec={0,1}; go ROUND (one retry only, tracked by a flag).
  - Otherwise, or retry already used: go DONE.
- DONE: done=1 for one cycle; op_err and zero valid; return to IDLE. start in DONE is ignored.
- Latency, start to done:
  - add, no retry: 6 cycles;
  - mult: MULT_CYCLES+4;
  - each retry adds 2.
- Shift and inc/dec amounts never exceed 26.

Optional Feature:
- Macro: UC_FP_ROUND_RETRY_EN.
- Defined: CHECK state and single post-round renormalization retry as above.
- Undefined: ROUND goes directly to DONE; round_fract is ignored; sinalMuxFP4 and sinalMuxFP5 are constant 0.

Test Plan:
- Add, exp_a=0x80, exp_b=0x82, exp_dif=2 -> sinalMuxFP1/2=1, FP3=0, sinalShiftFract=2; done 6 cycles after start.
- Add, exp_dif=40 -> sinalShiftFract=27 (saturated).
- Add, ula=0x0800000 (m=23) -> sinalShiftRes=0x102, sinalIncOrDec=0x102; ula=0x4000000 (m=26) -> both 0x001.
- Mult, op=01 -> mult_rst high exactly cycle 1; done at MULT_CYCLES+4 = 32 cycles; select outputs stay 0.
- ula=0 -> done with zero=1 and no ROUND cycle; op=11 -> done one cycle after start with op_err=1.
- round_fract[25]=1 in CHECK (macro defined) -> FP4=FP5=1, shift/inc {0,1}, sinalRound pulses a second time, done +2 cycles. Assert reset during MULT_WAIT -> all outputs 0 and IDLE immediately, no done.
